// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-logic datapath.
//   COORD_W   : width of board coordinates and of the shared subtractor
//   ST_*      : subtractor_arbiter FSM state encoding
//   REQ_*     : requester index assignments on the arbiter
package snake_pkg;

    localparam int COORD_W = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int REQ_WALL  = 0;
    localparam int REQ_FOOD  = 1;
    localparam int REQ_BODY  = 2;
    localparam int REQ_SCORE = 3;

endpackage

// File: rtl/subtractor_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   ID_W     index with highest priority this round
//   winner  out  ID_W     first set request scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ)
//   any     out  1        at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    always_comb begin
        int              sum;
        logic [ID_W-1:0] idx;
        sum    = 0;
        idx    = '0;
        winner = '0;
        any    = |req;
        // Scan from the farthest offset down so the closest one to rr_ptr is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/subtractor_arbiter.sv
// Shares one external WIDTH-bit subtractor among NUM_REQ requesters.
// Round-robin grant, operands latched at the grant edge, tagged result one
// cycle later with a locally computed unsigned borrow.
//   clk        in   1              system clock
//   rst        in   1              synchronous active-high reset
//   req        in   NUM_REQ        request per requester
//   op_a/op_b  in   NUM_REQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        out  NUM_REQ        one-hot, one-cycle grant pulse
//   busy       out  1              operation in flight
//   sub_a/b    out  WIDTH          to the subtractor
//   sub_d      in   WIDTH          subtractor result (combinational A-B)
//   res_valid  out  1              one-cycle result strobe
//   res_id     out  ID_W           owner of the result
//   res_diff   out  WIDTH          A-B modulo 2^WIDTH
//   res_neg    out  1              A < B
//
// state | meaning
// IDLE  | arbitrate; on a request latch winner operands and pulse gnt
// EXEC  | operands held on sub_a/sub_b while sub_d settles; capture result
// DONE  | res_valid pulse; no arbitration this cycle
module subtractor_arbiter
    import snake_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = COORD_W,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [WIDTH-1:0]         sub_a,
    output logic [WIDTH-1:0]         sub_b,
    input  logic [WIDTH-1:0]         sub_d,
    output logic                     res_valid,
    output logic [ID_W-1:0]          res_id,
    output logic [WIDTH-1:0]         res_diff,
    output logic                     res_neg
);

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    winner;
    logic               any;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic [NUM_REQ-1:0] win_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        win_a      = '0;
        win_b      = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                win_a         = op_a[i*WIDTH +: WIDTH];
                win_b         = op_b[i*WIDTH +: WIDTH];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            gnt       <= '0;
            sub_a     <= '0;
            sub_b     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_diff  <= '0;
            res_neg   <= 1'b0;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        sub_a  <= win_a;
                        sub_b  <= win_b;
                        id_q   <= winner;
                        gnt    <= win_onehot;
                        rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_diff  <= sub_d;
                    // The subtractor has no borrow output, so derive it from the held operands.
                    res_neg   <= (sub_a < sub_b);
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_arbiter.sv
module tb_subtractor_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 10;
    localparam int ID_W    = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] op_a;
    logic [NUM_REQ*WIDTH-1:0] op_b;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic [WIDTH-1:0]         sub_a;
    logic [WIDTH-1:0]         sub_b;
    logic [WIDTH-1:0]         sub_d;
    logic                     res_valid;
    logic [ID_W-1:0]          res_id;
    logic [WIDTH-1:0]         res_diff;
    logic                     res_neg;

    subtractor_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .busy      (busy),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_d     (sub_d),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_diff  (res_diff),
        .res_neg   (res_neg)
    );

    // External subtractor beside the arbiter.
    assign sub_d = sub_a - sub_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] diff;
        logic             neg;
    } exp_t;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [ID_W-1:0]    id;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [WIDTH-1:0]   diff;
        logic               neg;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input int diff, input logic neg);
        exp_t e;
        e.id   = ID_W'(id);
        e.diff = WIDTH'(diff);
        e.neg  = neg;
        sb_q.push_back(e);
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_a[i*WIDTH +: WIDTH] = a;
        op_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of falling edges until gnt is seen; 0 means it never came.
    task automatic wait_gnt(output int n);
        n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (|gnt) begin
                n = k;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL res_unexpected actual id=%0d diff=%0h required=no result", res_id, res_diff);
            end else begin
                mon_e = sb_q.pop_front();
                if ({res_id, res_diff, res_neg} !== {mon_e.id, mon_e.diff, mon_e.neg}) begin
                    errors++;
                    $display("FAIL res_data actual id=%0d diff=%0h neg=%0b required id=%0d diff=%0h neg=%0b",
                             res_id, res_diff, res_neg, mon_e.id, mon_e.diff, mon_e.neg);
                end
            end
        end
    end

    initial begin
        int n;
        int rr_id[5]   = '{0, 1, 2, 3, 0};
        int rr_diff[5] = '{190, 1014, 0, 899, 190};
        logic rr_neg[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        vecs[0] = '{req: 4'b0100, id: 2'd2, a: 10'd300,  b: 10'd45,   diff: 10'd255,  neg: 1'b0};
        vecs[1] = '{req: 4'b0001, id: 2'd0, a: 10'd3,    b: 10'd5,    diff: 10'h3FE,  neg: 1'b1};
        vecs[2] = '{req: 4'b0001, id: 2'd0, a: 10'd0,    b: 10'd0,    diff: 10'd0,    neg: 1'b0};
        vecs[3] = '{req: 4'b1000, id: 2'd3, a: 10'd1023, b: 10'd1,    diff: 10'd1022, neg: 1'b0};
        vecs[4] = '{req: 4'b0010, id: 2'd1, a: 10'd0,    b: 10'd1023, diff: 10'd1,    neg: 1'b1};
        vecs[5] = '{req: 4'b0100, id: 2'd2, a: 10'd512,  b: 10'd512,  diff: 10'd0,    neg: 1'b0};

        // Reset held with all requests pending.
        rst  = 1'b1;
        req  = 4'b1111;
        op_a = '1;
        op_b = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
        end
        chk("rst_fields", {res_id, res_diff, res_neg, sub_a, sub_b}, 0);
        drive_point();
        rst = 1'b0;
        req = '0;

        // Round robin with every request held.
        set_lane(0, 10'd200, 10'd10);
        set_lane(1, 10'd150, 10'd160);
        set_lane(2, 10'd40,  10'd40);
        set_lane(3, 10'd900, 10'd1);
        for (int k = 0; k < 5; k++) push_exp(rr_id[k], rr_diff[k], rr_neg[k]);
        drive_point();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(n);
            chk("rr_gnt", gnt, 1 << rr_id[k]);
            chk("rr_spacing", n, (k == 0) ? 2 : 3);
            if (k == 4) req = '0;
        end
        @(negedge clk);
        chk("rr_last_valid", res_valid, 1);
        @(negedge clk);
        chk("rr_stop_gnt", gnt, 0);
        chk("rr_stop_busy", busy, 0);

        // Single operations from the vector table.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NUM_REQ; i++) set_lane(i, WIDTH'(10'h2AA ^ i), WIDTH'(10'h155 + i));
            set_lane(int'(vecs[v].id), vecs[v].a, vecs[v].b);
            push_exp(int'(vecs[v].id), int'(vecs[v].diff), vecs[v].neg);
            drive_point();
            req = vecs[v].req;
            wait_gnt(n);
            chk("vec_gnt_lat", n, 2);
            chk("vec_gnt", gnt, vecs[v].req);
            chk("vec_busy", busy, 1);
            req = '0;
            set_lane(int'(vecs[v].id), 10'd7, 10'd900);
            @(negedge clk);
            chk("vec_valid", res_valid, 1);
            @(negedge clk);
            chk("vec_valid_pulse", res_valid, 0);
            chk("vec_hold", {res_id, res_diff, res_neg}, {vecs[v].id, vecs[v].diff, vecs[v].neg});
        end

        // Grant to 3, then contention from 3 and 0: pointer wraps to 0.
        set_lane(3, 10'd700, 10'd20);
        set_lane(0, 10'd50,  10'd60);
        push_exp(3, 680, 1'b0);
        drive_point();
        req = 4'b1000;
        wait_gnt(n);
        chk("cont_gnt3_lat", n, 2);
        chk("cont_gnt3", gnt, 4'b1000);
        req = 4'b1001;
        set_lane(3, 10'd5, 10'd900);
        push_exp(0, 1014, 1'b1);
        wait_gnt(n);
        chk("cont_gnt0_lat", n, 3);
        chk("cont_gnt0", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        chk("cont_valid", res_valid, 1);
        @(negedge clk);

        // Reset during EXEC drops the operation and the round-robin pointer.
        set_lane(0, 10'd77, 10'd7);
        drive_point();
        req = 4'b0001;
        wait_gnt(n);
        chk("mid_gnt", gnt, 4'b0001);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("mid_valid", res_valid, 0);
        chk("mid_busy", busy, 0);
        drive_point();
        rst = 1'b0;
        req = 4'b0011;
        set_lane(0, 10'd9, 10'd4);
        set_lane(1, 10'd8, 10'd1);
        push_exp(0, 5, 1'b0);
        wait_gnt(n);
        chk("post_rst_lat", n, 2);
        chk("post_rst_gnt", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        chk("post_rst_valid", res_valid, 1);
        repeat (2) @(negedge clk);

        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
